mem_stage: RTL and testbench

Memory-access stage between the EX/MEM pipeline register and the MEM/WB register. It decodes the instruction held in EX/MEM and performs LW/SW accesses against an internal word-addressed data memory with a fixed multi-cycle latency. While an access is in flight it stalls the front of the pipeline. When the access completes it produces the load data and the write enable that drive the MEM/WB register.

---
 rtl/mem_stage_if.sv | 21 ++
 rtl/mem_stage.sv | 142 ++++++++++++++
 tb/tb_mem_stage.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// EX/MEM -> memory-stage bundle: decoded instruction fields in, load data and pipeline control out.
interface mem_stage_if;
  logic        valid_i;
  logic [3:0]  op_i;
  logic [15:0] alu_data_i;
  logic [15:0] st_data_i;
  logic [15:0] mem_data_o;
  logic        wb_we_o;
  logic        stall_o;
  logic        busy_o;

  modport master (
    output valid_i, op_i, alu_data_i, st_data_i,
    input  mem_data_o, wb_we_o, stall_o, busy_o
  );

  modport slave (
    input  valid_i, op_i, alu_data_i, st_data_i,
    output mem_data_o, wb_we_o, stall_o, busy_o
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: fixed-latency LW/SW against an internal word-addressed array.
// Optional store-to-load forwarding register enabled by defining MEM_STFWD_EN.
module mem_stage #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned MEM_LAT = 4
) (
  input logic         clk,
  input logic         rst,
  mem_stage_if.slave  bus
);

  localparam int unsigned Depth   = 2 ** ADDR_W;
  localparam logic [3:0]  CntInit = 4'(MEM_LAT - 1);
  localparam logic [3:0]  OpLw    = 4'b1000;
  localparam logic [3:0]  OpSw    = 4'b1001;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [15:0]         mem_data_q, mem_data_d;
  logic [15:0]         mem_q [Depth];

  logic                is_ld, is_st, is_mem;
  logic                access;
  logic                fwd_hit;
  logic [ADDR_W-1:0]   idx;

  assign is_ld  = bus.valid_i & (bus.op_i == OpLw);
  assign is_st  = bus.valid_i & (bus.op_i == OpSw);
  assign is_mem = is_ld | is_st;
  // Byte address to word index; bit 0 and bits above ADDR_W are dropped so addresses alias.
  assign idx    = bus.alu_data_i[ADDR_W:1];
  assign access = (state_q == StBusy) && (cnt_q == 4'd0);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.alu_data_i[0], bus.alu_data_i[15:ADDR_W+1]};

`ifdef MEM_STFWD_EN
  logic              lst_v_q;
  logic [ADDR_W-1:0] lst_idx_q;
  logic [15:0]       lst_data_q;

  assign fwd_hit = (state_q == StIdle) && is_ld && lst_v_q && (idx == lst_idx_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      lst_v_q <= 1'b0;
    end else if (access && is_st) begin
      lst_v_q    <= 1'b1;
      lst_idx_q  <= idx;
      lst_data_q <= bus.st_data_i;
    end
  end
`else
  assign fwd_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      mem_data_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_data_q <= mem_data_d;
    end
  end

  // Array is not reset; a reset asserted on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && access && is_st) begin
      mem_q[idx] <= bus.st_data_i;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_data_d = mem_data_q;
    unique case (state_q)
      StIdle: begin
        if (fwd_hit) begin
`ifdef MEM_STFWD_EN
          mem_data_d = lst_data_q;
`endif
          state_d    = StDone;
        end else if (is_mem) begin
          cnt_d   = CntInit;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (is_ld) begin
            mem_data_d = mem_q[idx];
          end
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output logic
  always_comb begin
    bus.stall_o = 1'b0;
    bus.wb_we_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.stall_o = is_mem;
        bus.wb_we_o = bus.valid_i & ~is_mem;
      end
      StBusy: begin
        bus.stall_o = 1'b1;
        bus.wb_we_o = 1'b0;
      end
      StDone: begin
        bus.stall_o = 1'b0;
        bus.wb_we_o = 1'b1;
      end
      default: begin
        bus.stall_o = 1'b0;
        bus.wb_we_o = 1'b0;
      end
    endcase
  end

  assign bus.mem_data_o = mem_data_q;
  assign bus.busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for non-memory ops, hand sequences for LW/SW timing.
module tb_mem_stage;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned MEM_LAT = 4;
  localparam int          Full    = MEM_LAT + 1;
`ifdef MEM_STFWD_EN
  localparam int          Hit     = 1;
`else
  localparam int          Hit     = Full;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_stage_if bus ();

  mem_stage #(
    .ADDR_W (ADDR_W),
    .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic [15:0] alu;
    logic        exp_we;
    logic        exp_stall;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input logic [15:0] hold);
    for (int i = 0; i < 7; i++) begin
      bus.valid_i    = vecs[i].valid;
      bus.op_i       = vecs[i].op;
      bus.alu_data_i = vecs[i].alu;
      bus.st_data_i  = 16'h0;
      @(negedge clk);
      check($sformatf("vec%0d we", i), 16'(bus.wb_we_o), 16'(vecs[i].exp_we));
      check($sformatf("vec%0d stall", i), 16'(bus.stall_o), 16'(vecs[i].exp_stall));
      check($sformatf("vec%0d busy", i), 16'(bus.busy_o), 16'h0);
      check($sformatf("vec%0d hold", i), bus.mem_data_o, hold);
      next_cycle();
      check($sformatf("vec%0d no fsm move", i), 16'(bus.busy_o), 16'h0);
    end
    bus.valid_i = 1'b0;
    bus.op_i    = 4'h0;
  endtask

  task automatic mem_op(input string name, input logic st, input logic [15:0] addr,
                        input logic [15:0] data, input int exp_stall, input logic [15:0] exp_rd);
    int n;
    bit done;
    n    = 0;
    done = 0;
    bus.valid_i    = 1'b1;
    bus.op_i       = st ? 4'b1001 : 4'b1000;
    bus.alu_data_i = addr;
    bus.st_data_i  = data;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (bus.stall_o) begin
        n++;
        if (bus.wb_we_o !== 1'b0) check({name, " we during stall"}, 16'(bus.wb_we_o), 16'h0);
        next_cycle();
      end else begin
        done = 1;
      end
    end
    if (!done) check({name, " timeout"}, 16'h0, 16'h1);
    check({name, " stall cycles"}, 16'(n), 16'(exp_stall));
    check({name, " done we"}, 16'(bus.wb_we_o), 16'h1);
    check({name, " done busy"}, 16'(bus.busy_o), 16'h1);
    if (!st) check({name, " load data"}, bus.mem_data_o, exp_rd);
    next_cycle();
    bus.valid_i = 1'b0;
    bus.op_i    = 4'h0;
    @(negedge clk);
    check({name, " back to idle"}, 16'(bus.busy_o), 16'h0);
    next_cycle();
  endtask

  // Start an SW, then assert reset after 'cycles' edges into the access.
  task automatic aborted_sw(input string name, input logic [15:0] addr, input logic [15:0] data,
                            input int cycles);
    bus.valid_i    = 1'b1;
    bus.op_i       = 4'b1001;
    bus.alu_data_i = addr;
    bus.st_data_i  = data;
    repeat (cycles) next_cycle();
    rst         = 1'b1;
    bus.valid_i = 1'b0;
    bus.op_i    = 4'h0;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check({name, " busy after rst"}, 16'(bus.busy_o), 16'h0);
    check({name, " stall after rst"}, 16'(bus.stall_o), 16'h0);
    check({name, " data after rst"}, bus.mem_data_o, 16'h0000);
    next_cycle();
  endtask

  initial begin
    vecs[0] = '{valid: 1'b1, op: 4'b0000, alu: 16'h1234, exp_we: 1'b1, exp_stall: 1'b0};
    vecs[1] = '{valid: 1'b1, op: 4'b0111, alu: 16'h0010, exp_we: 1'b1, exp_stall: 1'b0};
    vecs[2] = '{valid: 1'b1, op: 4'b1010, alu: 16'h0020, exp_we: 1'b1, exp_stall: 1'b0};
    vecs[3] = '{valid: 1'b1, op: 4'b1111, alu: 16'hFFFF, exp_we: 1'b1, exp_stall: 1'b0};
    vecs[4] = '{valid: 1'b0, op: 4'b1000, alu: 16'h0010, exp_we: 1'b0, exp_stall: 1'b0};
    vecs[5] = '{valid: 1'b0, op: 4'b1001, alu: 16'h0040, exp_we: 1'b0, exp_stall: 1'b0};
    vecs[6] = '{valid: 1'b1, op: 4'b0001, alu: 16'h8001, exp_we: 1'b1, exp_stall: 1'b0};

    rst            = 1'b1;
    bus.valid_i    = 1'b0;
    bus.op_i       = 4'h0;
    bus.alu_data_i = 16'h0;
    bus.st_data_i  = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset mem_data", bus.mem_data_o, 16'h0000);
    check("reset we", 16'(bus.wb_we_o), 16'h0);
    check("reset stall", 16'(bus.stall_o), 16'h0);
    check("reset busy", 16'(bus.busy_o), 16'h0);
    next_cycle();

    run_table(16'h0000);

    mem_op("sw 0010", 1'b1, 16'h0010, 16'hBEEF, Full, 16'h0);
    mem_op("lw 0011", 1'b0, 16'h0011, 16'h0, Hit, 16'hBEEF);

    // 0x0800 wraps to word 0; it also matches the last store index when forwarding
    mem_op("sw 0000", 1'b1, 16'h0000, 16'hCAFE, Full, 16'h0);
    mem_op("lw 0800", 1'b0, 16'h0800, 16'h0, Hit, 16'hCAFE);

    run_table(16'hCAFE);

    mem_op("sw 0020 old", 1'b1, 16'h0020, 16'h5555, Full, 16'h0);
    aborted_sw("abort busy2", 16'h0020, 16'h1234, 2);
    mem_op("lw 0020", 1'b0, 16'h0020, 16'h0, Full, 16'h5555);

    mem_op("sw 0030 old", 1'b1, 16'h0030, 16'h1111, Full, 16'h0);
    aborted_sw("abort access", 16'h0030, 16'h7777, MEM_LAT);
    mem_op("lw 0030", 1'b0, 16'h0030, 16'h0, Full, 16'h1111);

    mem_op("sw 0042", 1'b1, 16'h0042, 16'h0042, Full, 16'h0);
    mem_op("sw 0040", 1'b1, 16'h0040, 16'h00AA, Full, 16'h0);
    mem_op("lw 0040", 1'b0, 16'h0040, 16'h0, Hit, 16'h00AA);
    mem_op("lw 0042", 1'b0, 16'h0042, 16'h0, Full, 16'h0042);
    mem_op("sw 0040 ovw", 1'b1, 16'h0040, 16'h00BB, Full, 16'h0);
    mem_op("lw 0040 ovw", 1'b0, 16'h0040, 16'h0, Hit, 16'h00BB);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
